div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Multi-cycle radix-2 restoring divider used by the EX stage for DIV/DIVU.
//   EX drives start_i with operands and holds its stall request to ctrl (req_from_ex) while busy_o=1.
//   Produces {remainder, quotient} for the HI/LO write path; one result per accepted start.
// PARAMETERS
//   WIDTH  32  operand width; result_o is 2*WIDTH; iteration count = WIDTH
// PORTS
//   clk           in   1        clock, all state updates on rising edge
//   rst           in   1        asynchronous, active-high reset (`RstEnable = 1'b1)
//   signed_div_i  in   1        1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     in   WIDTH    dividend
//   opdata2_i     in   WIDTH    divisor
//   start_i       in   1        request; held high by EX until result consumed
//   annul_i       in   1        abort in-flight division (flush/exception)
//   result_o      out  2*WIDTH  [2W-1:W] remainder, [W-1:0] quotient
//   ready_o       out  1        result_o valid
//   busy_o        out  1        division in progress (feeds EX stall request)
// BEHAVIOUR
//   Reset (async, any state): state=FREE, result_o=0, ready_o=0, busy_o=0, cnt=0.
//   States: FREE, BYZERO, ON, END; all outputs registered.
//   FREE: start_i=1 & annul_i=0 at edge E0 -> divisor==0 ? BYZERO : ON; cnt=0;
//     signed: latch |opdata1|, |opdata2| and sign flags; unsigned: raw operands.
//     start_i=0 or annul_i=1 -> stay FREE.
//   BYZERO: next edge -> END, result_o=0, ready_o=1.
//   ON: one iteration per edge: partial remainder shifted left 1 with next dividend MSB;
//     if rem >= divisor: rem -= divisor, quotient bit=1 else 0 (WIDTH+1-bit compare/subtract).
//     cnt increments; iterations at E1..E32 (WIDTH); at E32 -> END, ready_o=1, result_o loaded.
//     Latency start-accept edge -> ready_o high: WIDTH edges (32); BYZERO: 1 edge.
//   Sign fix (signed only, applied when loading result_o): quotient negated if dividend
//     and divisor signs differ; remainder takes dividend sign. 0x80000000 / -1 -> quotient
//     0x80000000, remainder 0 (two's-complement wrap, no trap).
//   END: ready_o=1, result_o stable while start_i=1; start_i=0 -> FREE, ready_o=0,
//     result_o cleared to 0. A new request therefore needs start_i low for >=1 cycle.
//   annul_i=1 in ON or BYZERO -> FREE next edge, ready_o stays 0, partial result discarded.
//     annul_i in END -> FREE, ready_o=0. annul_i has priority over start_i.
//   busy_o=1 exactly in ON and BYZERO. Operand inputs ignored outside FREE.
// CONFIGURATION
//   DIV_BYZERO_FLAG_EN defined: extra output div_by_zero_o (1 bit), set with ready_o when
//     the result came from BYZERO, cleared on leaving END / reset / annul.
//   Not defined: port absent; divide-by-zero silently returns result_o=0 with ready_o=1.
// STRUCTURE
//   defines.v: DivFree/DivByZero/DivOn/DivEnd 2-bit state codes, DivResultReady/NotReady,
//     DivStart/DivStop, DivAnnul constants.
//   Natural sub-module: div_sign_fix (combinational abs-in / negate-out); FSM+datapath in div_unit.
// TESTING
//   Unsigned 100/7, start held -> ready_o at 32 edges after accept, result_o={32'd2,32'd14}.
//   Signed -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 7/-2 -> q=-3, r=1.
//   Divisor 0 -> ready_o after 1 edge, result_o=0, busy_o high 1 cycle; with DIV_BYZERO_FLAG_EN div_by_zero_o=1.
//   annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises; next start 9/3 -> q=3, r=0.
//   Async rst asserted mid-ON (between edges) -> outputs 0 immediately; start after release runs full 32 cycles.
//   Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0; start_i held in END keeps ready_o/result_o stable.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg -- shared types and constants for the radix-2 restoring divider.
//   div_state_e : FSM state encoding (FREE / BYZERO / ON / END)
//   DIV_*       : handshake level constants used by the EX-stage interface
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_ANNUL            = 1'b1;

endpackage

// File: rtl/div_unit_sign_fix.sv
// div_unit_sign_fix -- combinational sign handling around the unsigned core.
//   Input side : signed_i, opdata1_i, opdata2_i -> magnitudes abs1_o/abs2_o and
//                the sign flags q_neg_o (operand signs differ) / r_neg_o (dividend negative).
//   Output side: quot_i/rem_i magnitudes plus q_neg_i/r_neg_i -> signed quot_o/rem_o.
//   Negating 0x80..0 yields 0x80..0, which gives the required wrap for MIN / -1.
module div_unit_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic [WIDTH-1:0] abs1_o,
  output logic [WIDTH-1:0] abs2_o,
  output logic             q_neg_o,
  output logic             r_neg_o,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic             q_neg_i,
  input  logic             r_neg_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic neg1, neg2;

  assign neg1    = signed_i & opdata1_i[WIDTH-1];
  assign neg2    = signed_i & opdata2_i[WIDTH-1];
  assign abs1_o  = neg1 ? (~opdata1_i + WIDTH'(1'b1)) : opdata1_i;
  assign abs2_o  = neg2 ? (~opdata2_i + WIDTH'(1'b1)) : opdata2_i;
  assign q_neg_o = neg1 ^ neg2;
  assign r_neg_o = neg1;

  assign quot_o  = q_neg_i ? (~quot_i + WIDTH'(1'b1)) : quot_i;
  assign rem_o   = r_neg_i ? (~rem_i + WIDTH'(1'b1)) : rem_i;

endmodule

// File: rtl/div_unit.sv
// div_unit -- multi-cycle radix-2 restoring divider for DIV/DIVU.
//   clk, rst (async active-high) ; signed_div_i selects DIV vs DIVU
//   opdata1_i dividend, opdata2_i divisor (sampled only when a start is accepted in FREE)
//   start_i request (held until result consumed), annul_i abort (priority over start_i)
//   result_o {remainder, quotient}, ready_o result valid, busy_o division in progress
//   Optional macro DIV_BYZERO_FLAG_EN adds div_by_zero_o, raised with ready_o for x/0.
// One iteration per edge for WIDTH edges; all outputs are registered.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
`ifdef DIV_BYZERO_FLAG_EN
  output logic               div_by_zero_o,
`endif
  output logic               busy_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   abs1, abs2, quot_fix, rem_fix, iter_rem, iter_quot;
  logic               q_neg_in, r_neg_in, qbit;
  logic [WIDTH:0]     trial, diff;

  div_unit_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_i  (signed_div_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .abs1_o    (abs1),
    .abs2_o    (abs2),
    .q_neg_o   (q_neg_in),
    .r_neg_o   (r_neg_in),
    .quot_i    (iter_quot),
    .rem_i     (iter_rem),
    .q_neg_i   (q_neg_q),
    .r_neg_i   (r_neg_q),
    .quot_o    (quot_fix),
    .rem_o     (rem_fix)
  );

  // Trial subtract on WIDTH+1 bits: the borrow bit says whether the divisor fits.
  assign trial     = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = trial - {1'b0, dvsr_q};
  assign qbit      = ~diff[WIDTH];
  assign iter_rem  = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign iter_quot = {dvd_q[WIDTH-2:0], qbit};

  // Next-state, datapath and registered-output logic of the divider FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    ready_d  = ready_q;
    busy_d   = 1'b0;
    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && annul_i != DIV_ANNUL) begin
          if (opdata2_i == {WIDTH{1'b0}}) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_ON;
          end
          cnt_d   = {CNT_W{1'b0}};
          dvd_d   = abs1;
          dvsr_d  = abs2;
          rem_d   = {WIDTH{1'b0}};
          q_neg_d = q_neg_in;
          r_neg_d = r_neg_in;
          busy_d  = 1'b1;
        end else begin
          state_d = DIV_FREE;
        end
      end
      DIV_BYZERO: begin
        if (annul_i == DIV_ANNUL) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = {2*WIDTH{1'b0}};
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i == DIV_ANNUL) begin
          state_d = DIV_FREE;
        end else begin
          rem_d = iter_rem;
          dvd_d = iter_quot;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DIV_END;
            ready_d  = DIV_RESULT_READY;
            result_d = {rem_fix, quot_fix};
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      DIV_END: begin
        if (annul_i == DIV_ANNUL || start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = {2*WIDTH{1'b0}};
        end else begin
          state_d = DIV_END;
        end
      end
      default: begin
        state_d  = DIV_FREE;
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = {2*WIDTH{1'b0}};
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= {CNT_W{1'b0}};
      dvd_q    <= {WIDTH{1'b0}};
      dvsr_q   <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= {2*WIDTH{1'b0}};
      ready_q  <= DIV_RESULT_NOT_READY;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

`ifdef DIV_BYZERO_FLAG_EN
  logic dbz_q, dbz_d;

  // Flag follows the END state and remembers whether END was entered from BYZERO.
  always_comb begin
    if (state_d == DIV_END) begin
      dbz_d = dbz_q | (state_q == DIV_BYZERO);
    end else begin
      dbz_d = 1'b0;
    end
  end

  // Divide-by-zero flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign div_by_zero_o = dbz_q;
`endif

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule
